// File: rtl/vec_alu_seq.sv
// Multi-cycle signed vector ALU: VADD/SMUL/VDOT with saturation plus scalar 16-bit ops.
// Latency: out_valid rises NC edges after acceptance (NC = LANES/LANES_PER_CYC for vector ops, 1 otherwise).
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready, with no accept on the consume edge.
module vec_alu_seq #(
  parameter int LANES         = 16,
  parameter int LANE_W        = 16,
  parameter int LANES_PER_CYC = 4,
  localparam int VW           = LANES * LANE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    opcode,
  input  logic [VW-1:0] op_1,
  input  logic [VW-1:0] op_2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] result,
  output logic          ovf,
  output logic          bad_op
);

  localparam int NC_MAX = LANES / LANES_PER_CYC;
  localparam int CNT_W  = (NC_MAX > 1) ? $clog2(NC_MAX) : 1;
  // Wide enough that a full dot product of LANES lanes can never wrap.
  localparam int ACC_W  = 2 * LANE_W + $clog2(LANES);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;
  localparam logic [3:0] OP_SST  = 4'b0011;
  localparam logic [3:0] OP_VLD  = 4'b0100;
  localparam logic [3:0] OP_VST  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SLH  = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              opcode_r;
  logic [VW-1:0]           op1_r;
  logic [VW-1:0]           op2_r;
  logic [VW-1:0]           res_r;
  logic                    ovf_r;
  logic                    bad_r;
  logic signed [ACC_W-1:0] acc;

  logic [VW-1:0]           next_res;
  logic signed [ACC_W-1:0] next_acc;
  logic signed [ACC_W-1:0] dot_part;
  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] s_ext;
  logic signed [ACC_W-1:0] raw_v;
  logic [LANE_W:0]         sat_v;
  logic                    clamp_any;
  logic                    bad_n;
  logic                    is_vec;
  logic                    last;
  int                      idx;

  // Clamp a wide signed value into one lane; MSB of the return flags a clamp.
  function automatic logic [LANE_W:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > MAX_V)      return {1'b1, MAX_V[LANE_W-1:0]};
    else if (v < MIN_V) return {1'b1, MIN_V[LANE_W-1:0]};
    else                return {1'b0, v[LANE_W-1:0]};
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = res_r;
  assign ovf       = ovf_r;
  assign bad_op    = bad_r;

  assign is_vec = (opcode_r == OP_VADD) || (opcode_r == OP_VDOT) || (opcode_r == OP_SMUL);
  assign last   = !is_vec || (cnt == CNT_W'(NC_MAX - 1));

  // Result of the current BUSY edge: one chunk of lanes for vector ops, the whole answer for scalar ops.
  always_comb begin
    next_res  = res_r;
    next_acc  = acc;
    dot_part  = '0;
    a_ext     = '0;
    b_ext     = '0;
    raw_v     = '0;
    sat_v     = '0;
    idx       = 0;
    clamp_any = 1'b0;
    bad_n     = 1'b0;
    s_ext     = {{(ACC_W-LANE_W){op1_r[LANE_W-1]}}, op1_r[LANE_W-1:0]};
    case (opcode_r)
      OP_VADD, OP_SMUL: begin
        for (int j = 0; j < LANES_PER_CYC; j++) begin
          idx   = int'(cnt) * LANES_PER_CYC + j;
          a_ext = {{(ACC_W-LANE_W){op1_r[idx*LANE_W+LANE_W-1]}}, op1_r[idx*LANE_W +: LANE_W]};
          b_ext = {{(ACC_W-LANE_W){op2_r[idx*LANE_W+LANE_W-1]}}, op2_r[idx*LANE_W +: LANE_W]};
          raw_v = (opcode_r == OP_VADD) ? (a_ext + b_ext) : (s_ext * b_ext);
          sat_v = sat(raw_v);
          next_res[idx*LANE_W +: LANE_W] = sat_v[LANE_W-1:0];
          clamp_any = clamp_any | sat_v[LANE_W];
        end
      end
      OP_VDOT: begin
        for (int j = 0; j < LANES_PER_CYC; j++) begin
          idx      = int'(cnt) * LANES_PER_CYC + j;
          a_ext    = {{(ACC_W-LANE_W){op1_r[idx*LANE_W+LANE_W-1]}}, op1_r[idx*LANE_W +: LANE_W]};
          b_ext    = {{(ACC_W-LANE_W){op2_r[idx*LANE_W+LANE_W-1]}}, op2_r[idx*LANE_W +: LANE_W]};
          dot_part = dot_part + a_ext * b_ext;
        end
        next_acc = acc + dot_part;
        if (last) begin
          sat_v = sat(next_acc);
          next_res[LANE_W-1:0] = sat_v[LANE_W-1:0];
          clamp_any = sat_v[LANE_W];
        end
      end
      OP_VLD, OP_VST, OP_SST: begin
        next_res = '0;
        next_res[15:0] = op1_r[15:0] + op2_r[15:0];
      end
      OP_SLL: begin
        next_res = '0;
        next_res[15:0] = {op1_r[15:8], op2_r[7:0]};
      end
      OP_SLH: begin
        next_res = '0;
        next_res[15:0] = {op2_r[7:0], op1_r[7:0]};
      end
      OP_NOP: begin
        next_res = '0;
      end
      default: begin
        next_res = '0;
        bad_n    = 1'b1;
      end
    endcase
  end

  // Handshake FSM plus operand, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      opcode_r <= '0;
      op1_r    <= '0;
      op2_r    <= '0;
      res_r    <= '0;
      ovf_r    <= 1'b0;
      bad_r    <= 1'b0;
      acc      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            opcode_r <= opcode;
            op1_r    <= op_1;
            op2_r    <= op_2;
            res_r    <= '0;
            acc      <= '0;
            ovf_r    <= 1'b0;
            bad_r    <= 1'b0;
            cnt      <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          res_r <= next_res;
          acc   <= next_acc;
          ovf_r <= ovf_r | clamp_any;
          bad_r <= bad_n;
          if (last) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed bench for vec_alu_seq with hand-computed expected vectors.
// Each operation is issued from IDLE and its latency is counted in edges until out_valid.
// Results are held in DONE by out_ready=0 until the bench consumes them.
module tb_vec_alu_seq;
  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int LPC    = 4;
  localparam int VW     = LANES * LANE_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [VW-1:0] op_1;
  logic [VW-1:0] op_2;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] result;
  logic          ovf;
  logic          bad_op;

  int n_cmp = 0;
  int n_bad = 0;

  vec_alu_seq #(.LANES(LANES), .LANE_W(LANE_W), .LANES_PER_CYC(LPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op_1(op_1), .op_2(op_2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ovf(ovf), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] lane(input int i, input logic [15:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[i*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] splat(input logic [15:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  // Present one operation from IDLE, then count edges until out_valid (bounded).
  task automatic issue(input string tag, input logic [3:0] op, input logic [VW-1:0] a,
                       input logic [VW-1:0] b, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_rdy_before"}, in_ready, 1);
    opcode   = op;
    op_1     = a;
    op_2     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_idle_rdy"}, in_ready, 1);
    check({tag, "_idle_vld"}, out_valid, 0);
  endtask

  initial begin
    logic [VW-1:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 4'hF;
    op_1      = '0;
    op_2      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, '0);
    check("rst_ovf", ovf, 0);
    check("rst_bad_op", bad_op, 0);
    @(negedge clk) rst_n = 1'b1;

    // Scalar add wraps modulo 2^16; upper operand lanes must not leak into the result.
    issue("vld", 4'b0100, lane(0, 16'hFFFF) | lane(1, 16'h7FFF), lane(0, 16'h0002) | lane(3, 16'h1111), 1);
    check("vld_res", result, lane(0, 16'h0001));
    check("vld_ovf", ovf, 0);
    check("vld_bad", bad_op, 0);
    consume("vld");

    // Reset during BUSY of a VADD abandons it.
    @(negedge clk);
    opcode = 4'b0000; op_1 = splat(16'h0001); op_2 = splat(16'h0001); in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_result", result, '0);
    @(negedge clk) rst_n = 1'b1;

    issue("nop", 4'b1111, splat(16'h1234), splat(16'h4321), 1);
    check("nop_res", result, '0);
    check("nop_ovf", ovf, 0);
    consume("nop");

    // Saturating VADD, including a lane in the last chunk.
    issue("vadd", 4'b0000,
          lane(0, 16'h7FFF) | lane(1, 16'h8000) | lane(2, 16'h0003) | lane(15, 16'h1234),
          lane(0, 16'h0001) | lane(1, 16'hFFFF) | lane(2, 16'h0004) | lane(15, 16'h0100), 4);
    check("vadd_res", result,
          lane(0, 16'h7FFF) | lane(1, 16'h8000) | lane(2, 16'h0007) | lane(15, 16'h1334));
    check("vadd_ovf", ovf, 1);
    consume("vadd");

    issue("vdot_small", 4'b0001, splat(16'h0002), splat(16'h0003), 4);
    check("vdot_small_res", result, lane(0, 16'h0060));
    check("vdot_small_ovf", ovf, 0);
    consume("vdot_small");

    issue("vdot_pos", 4'b0001, splat(16'h7FFF), splat(16'h7FFF), 4);
    check("vdot_pos_res", result, lane(0, 16'h7FFF));
    check("vdot_pos_ovf", ovf, 1);
    consume("vdot_pos");

    issue("vdot_neg", 4'b0001, splat(16'h8000), splat(16'h7FFF), 4);
    check("vdot_neg_res", result, lane(0, 16'h8000));
    check("vdot_neg_ovf", ovf, 1);
    consume("vdot_neg");

    // Scalar comes from op_1 lane 0 only; other op_1 lanes are ignored.
    issue("smul", 4'b0010, lane(0, 16'h0100) | lane(1, 16'h5555),
          lane(0, 16'h0100) | lane(1, 16'h0002), 4);
    check("smul_res", result, lane(0, 16'h7FFF) | lane(1, 16'h0200));
    check("smul_ovf", ovf, 1);
    consume("smul");

    issue("sll", 4'b0110, lane(0, 16'hABCD), lane(0, 16'h3412), 1);
    check("sll_res", result, lane(0, 16'hAB12));
    consume("sll");

    issue("bad", 4'b1010, splat(16'hFFFF), splat(16'hFFFF), 1);
    check("bad_res", result, '0);
    check("bad_flag", bad_op, 1);
    consume("bad");

    issue("slh", 4'b0111, lane(0, 16'hABCD), lane(0, 16'h3412), 1);
    check("slh_res", result, lane(0, 16'h12CD));
    check("slh_bad_clr", bad_op, 0);

    // Back-pressure: hold DONE for 5 cycles while a new SST is offered.
    held = result;
    @(negedge clk);
    opcode = 4'b0011; op_1 = lane(0, 16'h0100); op_2 = lane(0, 16'h0023); in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_result", result, held);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_consume_rdy", in_ready, 1);
    check("bp_consume_hold", result, held);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_accept", in_ready, 0);
    @(posedge clk);
    #1;
    check("bp_new_vld", out_valid, 1);
    check("bp_new_res", result, lane(0, 16'h0123));
    consume("sst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Multi-cycle, parametrised vector ALU that replaces the combinational 256-bit execute-stage ALU.
- Operates on LANES signed lanes of LANE_W bits and processes LANES_PER_CYC lanes per clock.
- Adds working VDOT and SMUL, saturating arithmetic, an overflow flag and a valid/ready handshake on both sides.
- Sits between operand fetch and writeback; the pipeline stalls on in_ready.

Parameters:
- LANES, 16, number of vector lanes.
- LANE_W, 16, bits per lane, signed two's complement.
- LANES_PER_CYC, 4, lanes processed per BUSY cycle; must divide LANES.
- VW, LANES*LANE_W, full vector width (derived, not overridable); must be >= 16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an operation.
- opcode  in  4  0000 VADD, 0001 VDOT, 0010 SMUL, 0011 SST, 0100 VLD, 0101 VST, 0110 SLL, 0111 SLH, 1111 NOP.
- op_1  in  VW  operand 1.
- op_2  in  VW  operand 2.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  VW  result vector.
- ovf  out  1  at least one saturation occurred in this result.
- bad_op  out  1  opcode not in the list above.

Behaviour:
- Reset is asynchronous on rst_n low: state IDLE, in_ready=1, out_valid=0, result=0, ovf=0, bad_op=0, chunk counter=0. Reset mid-operation abandons the operation; no output is produced.
- State IDLE, in_ready=1:
  - When in_valid is high at an edge, register opcode, op_1 and op_2, clear accumulator, ovf and bad_op, go to BUSY.
  - Operands change only on acceptance.
- State BUSY, in_ready=0:
  - Each edge processes chunk cnt (lanes cnt*LANES_PER_CYC .. +LANES_PER_CYC-1) and increments cnt.
  - When cnt reaches NC-1, go to DONE.
  - NC = LANES/LANES_PER_CYC for VADD, VDOT and SMUL; NC = 1 for all other opcodes.
- State DONE: out_valid=1 and result/ovf/bad_op held stable. At an edge with out_ready=1, go to IDLE. No new operation is accepted in the same cycle as the result is consumed.
- Latency: out_valid rises NC edges after the acceptance edge. Maximum throughput is one operation per NC+2 cycles.
- Result by opcode:
  - VADD: lane i = sat(op_1[i] + op_2[i]).
  - SMUL: lane i = sat(s * op_2[i]), where s = op_1 lane 0.
  - VDOT: accumulator width 2*LANE_W + clog2(LANES), no internal overflow possible. Lane 0 = sat(sum of op_1[i]*op_2[i]); all other lanes 0.
  - VLD, VST, SST: result[15:0] = op_1[15:0] + op_2[15:0] modulo 2^16 (wraps, ovf not set); upper bits 0.
  - SLL: result[15:0] = {op_1[15:8], op_2[7:0]}; upper bits 0.
  - SLH: result[15:0] = {op_2[7:0], op_1[7:0]}; upper bits 0.
  - NOP: result 0.
  - Undefined opcode: result 0 and bad_op=1; the handshake still completes.
- Saturation sat(): clamp to [-2^(LANE_W-1), 2^(LANE_W-1)-1]. ovf is the OR over every clamp in the operation.
- Lanes not yet processed in BUSY are don't-care internally. Only DONE values are architectural.
- result/ovf/bad_op keep their last value after leaving DONE, until the next acceptance overwrites them.
- Inputs seen while in_ready=0 are ignored.

Test Plan:
- Reset: assert rst_n=0 during BUSY of a VADD -> out_valid=0, in_ready=1, result=0 immediately. Release, then issue NOP -> out_valid after 1 edge, result=0.
- VADD saturation (defaults): lane0 0x7FFF+0x0001, lane1 0x8000+0xFFFF, lane2 0x0003+0x0004 -> lanes 0x7FFF, 0x8000, 0x0007; ovf=1; out_valid exactly 4 edges after acceptance.
- VDOT: all op_1 lanes 0x0002, all op_2 lanes 0x0003 -> lane0 0x0060, other lanes 0, ovf=0. All lanes 0x7FFF·0x7FFF -> lane0 0x7FFF, ovf=1.
- SMUL: op_1 lane0 0x0100, op_2 lane0 0x0100, lane1 0x0002 -> lane0 0x7FFF, lane1 0x0200, ovf=1.
- Scalar ops: VLD with 0xFFFF+0x0002 -> result 0x0001, ovf=0, 1-edge latency. SLL with op_1=0xABCD, op_2 low byte 0x12 -> 0xAB12. SLH with the same operands -> 0x12CD. Opcode 1010 -> result 0, bad_op=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next edge, then the next operation is accepted.
